// File: rtl/life_sequencer_pkg.sv
// Shared types for the Game-of-Life sequencer and its evolution datapath:
// grid geometry, the packed grid type and the sequencer state enumeration.
package life_sequencer_pkg;

  localparam int GRID_ROWS  = 5;
  localparam int GRID_COLS  = 5;
  localparam int GRID_CELLS = GRID_ROWS * GRID_COLS;

  // Cell (row, col) lives at bit row*GRID_COLS + col.
  typedef logic [GRID_CELLS-1:0] grid_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PAUSED  = 2'd1,
    RUNNING = 2'd2,
    HALTED  = 2'd3
  } life_state_t;

  // True when no cell of the grid is alive.
  function automatic logic grid_is_empty(input grid_t g);
    return ~|g;
  endfunction

endpackage

// File: rtl/life_sequencer_tick_divider.sv
// Free-running generation timer: pulses tick on the TICK_DIV-th enabled cycle
// since the last clear, then wraps. Clear has priority over counting.
module tick_divider #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [31:0] TERMINAL = TICK_DIV - 32'd1;

  logic [31:0] count_reg;
  logic [31:0] count_next;

  assign tick = en && (count_reg == TERMINAL);

  // Next count: clear, wrap on terminal, else advance while enabled.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en) begin
      count_next = tick ? 32'd0 : count_reg + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Game-of-Life generation sequencer. Holds the current grid, loads seeds,
// and commits the external datapath's grid_next either on a timer tick
// (free-run) or on a step pulse (paused). Optionally halts once the pattern
// becomes a still life or dies out.
module life_sequencer
  import life_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int          GEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  grid_t            seed,
  output logic             seed_ready,
  input  logic             run,
  input  logic             step,
  input  logic             halt_en,
  input  grid_t            grid_next,
  output grid_t            grid,
  output logic [GEN_W-1:0] gen_count,
  output logic             gen_valid,
  output logic             stable,
  output logic             extinct,
  output logic             halted
);

  localparam logic [GEN_W-1:0] GEN_MAX = {GEN_W{1'b1}};

  life_state_t      state_reg, state_next;
  grid_t            cur_grid_reg, cur_grid_next;
  logic [GEN_W-1:0] gen_count_reg, gen_count_next;
  logic             gen_valid_reg, gen_valid_next;
  logic             stable_reg, stable_next;
  logic             extinct_reg, extinct_next;
  logic             ready_reg;

  logic  seed_load;
  logic  running_now;
  logic  tick;
  logic  step_commit;
  logic  commit;
  logic  next_same;
  logic  next_zero;
  logic  seed_zero;
  grid_t diff_bits;

  // A seed is accepted whenever offered once out of reset; it overrides any
  // commit that would otherwise happen in the same cycle.
  assign seed_load   = seed_valid && ready_reg;
  assign running_now = (state_reg == RUNNING) && run;
  assign step_commit = (state_reg == PAUSED) && step;
  assign commit      = !seed_load && (tick || step_commit);

  // Per-cell change detect between the current and evolved generation.
  for (genvar gi = 0; gi < GRID_CELLS; gi++) begin : g_diff
    assign diff_bits[gi] = grid_next[gi] ^ cur_grid_reg[gi];
  end

  assign next_same = ~|diff_bits;
  assign next_zero = grid_is_empty(grid_next);
  assign seed_zero = grid_is_empty(seed);

  // The timer only counts while actually free-running; any pause, seed load
  // or other state restarts the interval from zero.
  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk (clk),
    .rst (rst),
    .clr (seed_load || !running_now),
    .en  (running_now),
    .tick(tick)
  );

  // Next-state logic: seed load first, then commit-triggered halt, then run level.
  always_comb begin
    state_next = state_reg;
    if (seed_load) begin
      if (seed_zero && halt_en) begin
        state_next = HALTED;
      end else if (run) begin
        state_next = RUNNING;
      end else begin
        state_next = PAUSED;
      end
    end else if (commit && halt_en && (next_same || next_zero)) begin
      state_next = HALTED;
    end else begin
      case (state_reg)
        PAUSED:  if (run)  state_next = RUNNING;
        RUNNING: if (!run) state_next = PAUSED;
        default: state_next = state_reg;
      endcase
    end
  end

  // Datapath next values: seed load or generation commit, otherwise hold.
  always_comb begin
    cur_grid_next  = cur_grid_reg;
    gen_count_next = gen_count_reg;
    gen_valid_next = 1'b0;
    stable_next    = stable_reg;
    extinct_next   = extinct_reg;
    if (seed_load) begin
      cur_grid_next  = seed;
      gen_count_next = '0;
      gen_valid_next = 1'b1;
      stable_next    = 1'b0;
      extinct_next   = seed_zero;
    end else if (commit) begin
      cur_grid_next  = grid_next;
      gen_count_next = (gen_count_reg == GEN_MAX) ? GEN_MAX
                                                  : gen_count_reg + GEN_W'(1);
      gen_valid_next = 1'b1;
      stable_next    = next_same;
      extinct_next   = next_zero;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Grid, counters and status flags; an empty grid reads as extinct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_grid_reg  <= '0;
      gen_count_reg <= '0;
      gen_valid_reg <= 1'b0;
      stable_reg    <= 1'b0;
      extinct_reg   <= 1'b1;
    end else begin
      cur_grid_reg  <= cur_grid_next;
      gen_count_reg <= gen_count_next;
      gen_valid_reg <= gen_valid_next;
      stable_reg    <= stable_next;
      extinct_reg   <= extinct_next;
    end
  end

  // Ready drops with reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
    end
  end

  assign seed_ready = ready_reg;
  assign grid       = cur_grid_reg;
  assign gen_count  = gen_count_reg;
  assign gen_valid  = gen_valid_reg;
  assign stable     = stable_reg;
  assign extinct    = extinct_reg;
  assign halted     = (state_reg == HALTED);

endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: supplies a Game-of-Life datapath, drives directed
// scenarios and compares every cycle against a behavioural model, with
// literal expectations at key points.
module tb_life_sequencer;
  import life_sequencer_pkg::*;

  localparam int TD      = 4;
  localparam int GW      = 3;
  localparam int GEN_TOP = 7;

  localparam logic [1:0] M_EMPTY   = 2'd0;
  localparam logic [1:0] M_PAUSED  = 2'd1;
  localparam logic [1:0] M_RUNNING = 2'd2;
  localparam logic [1:0] M_HALTED  = 2'd3;

  localparam grid_t BLINK_H = 25'h0003800;  // row 2, cols 1..3
  localparam grid_t BLINK_V = 25'h0021080;  // col 2, rows 1..3
  localparam grid_t BLOCK   = 25'h00018C0;  // rows 1..2, cols 1..2
  localparam grid_t SINGLE  = 25'h0001000;  // centre cell
  localparam grid_t ZERO    = 25'h0000000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seed_valid = 1'b0;
  grid_t         seed = '0;
  logic          seed_ready;
  logic          run = 1'b1;
  logic          step = 1'b1;
  logic          halt_en = 1'b0;
  grid_t         grid_next;
  grid_t         grid;
  logic [GW-1:0] gen_count;
  logic          gen_valid;
  logic          stable;
  logic          extinct;
  logic          halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  life_sequencer #(
    .TICK_DIV(TD),
    .GEN_W   (GW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_valid(seed_valid),
    .seed      (seed),
    .seed_ready(seed_ready),
    .run       (run),
    .step      (step),
    .halt_en   (halt_en),
    .grid_next (grid_next),
    .grid      (grid),
    .gen_count (gen_count),
    .gen_valid (gen_valid),
    .stable    (stable),
    .extinct   (extinct),
    .halted    (halted)
  );

  // Conway's rules on a bounded 5x5 field (cells outside are dead).
  function automatic grid_t life_evolve(input grid_t g);
    grid_t n;
    int cnt;
    n = '0;
    for (int r = 0; r < GRID_ROWS; r++) begin
      for (int c = 0; c < GRID_COLS; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < GRID_ROWS &&
                (c + dc) >= 0 && (c + dc) < GRID_COLS) begin
              if (g[(r + dr) * GRID_COLS + (c + dc)]) cnt++;
            end
          end
        end
        if (g[r * GRID_COLS + c]) n[r * GRID_COLS + c] = (cnt == 2 || cnt == 3);
        else                      n[r * GRID_COLS + c] = (cnt == 3);
      end
    end
    return n;
  endfunction

  assign grid_next = life_evolve(grid);

  // Behavioural model state.
  typedef struct packed {
    grid_t       grid;
    logic [31:0] gen;
    logic        stable;
    logic        ext;
    logic        gv;
    logic        ready;
    logic [1:0]  mode;
    logic [31:0] cnt;
  } model_t;

  model_t ms;

  function automatic model_t model_reset();
    model_t m;
    m.grid = '0; m.gen = 0; m.stable = 1'b0; m.ext = 1'b1; m.gv = 1'b0;
    m.ready = 1'b0; m.mode = M_EMPTY; m.cnt = 0;
    return m;
  endfunction

  // One clock of the model from the requirement rules, using current inputs.
  function automatic model_t model_next(input model_t m);
    model_t n;
    logic   commit;
    grid_t  evo;
    n = m;
    n.gv = 1'b0;
    commit = 1'b0;
    if (seed_valid && m.ready) begin
      n.grid = seed; n.gen = 0; n.cnt = 0; n.stable = 1'b0;
      n.ext = (seed == '0); n.gv = 1'b1;
      if (seed == '0 && halt_en) n.mode = M_HALTED;
      else if (run)              n.mode = M_RUNNING;
      else                       n.mode = M_PAUSED;
    end else begin
      if (m.mode == M_PAUSED && step) commit = 1'b1;
      if (m.mode == M_RUNNING && run) begin
        n.cnt = m.cnt + 1;
        if (n.cnt == TD) begin
          commit = 1'b1;
          n.cnt = 0;
        end
      end else begin
        n.cnt = 0;
      end
      if (commit) begin
        evo = life_evolve(m.grid);
        n.stable = (evo == m.grid);
        n.ext = (evo == '0);
        n.grid = evo;
        n.gen = (m.gen >= GEN_TOP) ? GEN_TOP : m.gen + 1;
        n.gv = 1'b1;
      end
      if (commit && halt_en && (n.stable || n.ext)) n.mode = M_HALTED;
      else if (m.mode == M_PAUSED && run)           n.mode = M_RUNNING;
      else if (m.mode == M_RUNNING && !run)         n.mode = M_PAUSED;
    end
    n.ready = 1'b1;
    return n;
  endfunction

  // Model register, reset alongside the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) ms <= model_reset();
    else     ms <= model_next(ms);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("grid", 32'(grid), 32'(ms.grid));
    chk("gen_count", 32'(gen_count), ms.gen);
    chk("gen_valid", 32'(gen_valid), 32'(ms.gv));
    chk("stable", 32'(stable), 32'(ms.stable));
    chk("extinct", 32'(extinct), 32'(ms.ext));
    chk("halted", 32'(halted), 32'(ms.mode == M_HALTED));
    chk("seed_ready", 32'(seed_ready), 32'(ms.ready));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a seed for one cycle; returns 1 time unit after the load edge.
  task automatic load_seed(input grid_t s, input logic h);
    seed = s;
    halt_en = h;
    seed_valid = 1'b1;
    @(posedge clk);
    #1;
    seed_valid = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
  endtask

  initial begin
    // Reset with run/step active: nothing may leak through.
    cycles(3);
    chk("lit_rst_grid", 32'(grid), 32'(ZERO));
    chk("lit_rst_extinct", 32'(extinct), 32'd1);
    chk("lit_rst_ready", 32'(seed_ready), 32'd0);
    rst = 1'b0;
    // EMPTY ignores run and step.
    cycles(6);
    pulse_step();
    chk("lit_empty_gen", 32'(gen_count), 32'd0);
    chk("lit_empty_ready", 32'(seed_ready), 32'd1);

    // Blinker free-running, commits every TD cycles.
    run = 1'b1;
    load_seed(BLINK_H, 1'b0);
    chk("lit_blink_load_gv", 32'(gen_valid), 32'd1);
    cycles(12);
    chk("lit_blink_gen3", 32'(gen_count), 32'd3);
    chk("lit_blink_vert", 32'(grid), 32'(BLINK_V));
    chk("lit_blink_stable", 32'(stable), 32'd0);
    // Ten commits total: counter saturates, grid keeps oscillating.
    cycles(28);
    chk("lit_sat_gen", 32'(gen_count), 32'(GEN_TOP));
    chk("lit_sat_horiz", 32'(grid), 32'(BLINK_H));

    // Seed load collides with the next tick commit.
    cycles(3);
    load_seed(SINGLE, 1'b0);
    chk("lit_collide_grid", 32'(grid), 32'(SINGLE));
    chk("lit_collide_gen", 32'(gen_count), 32'd0);
    run = 1'b0;
    cycles(2);

    // Still life with auto-halt; later steps ignored.
    load_seed(BLOCK, 1'b1);
    pulse_step();
    chk("lit_block_gen", 32'(gen_count), 32'd1);
    chk("lit_block_stable", 32'(stable), 32'd1);
    chk("lit_block_halted", 32'(halted), 32'd1);
    pulse_step();
    pulse_step();
    chk("lit_block_hold", 32'(gen_count), 32'd1);

    // Extinction halt, then an all-zero seed halting immediately.
    load_seed(SINGLE, 1'b1);
    pulse_step();
    chk("lit_single_ext", 32'(extinct), 32'd1);
    chk("lit_single_halt", 32'(halted), 32'd1);
    chk("lit_single_grid", 32'(grid), 32'(ZERO));
    load_seed(ZERO, 1'b1);
    chk("lit_zero_halt", 32'(halted), 32'd1);
    chk("lit_zero_gen", 32'(gen_count), 32'd0);

    // Without halt_en a stable grid keeps committing.
    load_seed(ZERO, 1'b0);
    pulse_step();
    pulse_step();
    chk("lit_nohalt_gen", 32'(gen_count), 32'd2);
    chk("lit_nohalt_halted", 32'(halted), 32'd0);

    // Pause/resume around steps and ticks.
    load_seed(BLINK_H, 1'b1);
    pulse_step();
    run = 1'b1;
    cycles(6);
    pulse_step();
    run = 1'b0;
    cycles(3);
    pulse_step();
    cycles(2);

    // Reset in the middle of a tick interval.
    run = 1'b1;
    load_seed(BLINK_H, 1'b0);
    cycles(2);
    rst = 1'b1;
    #1;
    chk("lit_midrst_grid", 32'(grid), 32'(ZERO));
    chk("lit_midrst_gen", 32'(gen_count), 32'd0);
    chk("lit_midrst_ext", 32'(extinct), 32'd1);
    chk("lit_midrst_ready", 32'(seed_ready), 32'd0);
    chk("lit_midrst_gv", 32'(gen_valid), 32'd0);
    cycles(2);
    rst = 1'b0;
    cycles(10);
    pulse_step();
    chk("lit_post_rst_gen", 32'(gen_count), 32'd0);
    chk("lit_post_rst_grid", 32'(grid), 32'(ZERO));
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_sequencer.md
LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25_000_000: clock cycles between generations while running (legal range 1..2^32-1).
REQ-002 SHALL have parameter GEN_W, default 16: generation counter width.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port seed_valid  input  1  load request; seed accepted when seed_valid & seed_ready.
REQ-006 SHALL have port seed  input  grid_t  initial pattern.
REQ-007 SHALL have port seed_ready  output  1  block can accept a seed.
REQ-008 SHALL have port run  input  1  level; 1 = free-run, 0 = pause.
REQ-009 SHALL have port step  input  1  single-cycle pulse; advance one generation while paused.
REQ-010 SHALL have port halt_en  input  1  enable auto-halt on still-life or extinction.
REQ-011 SHALL have port grid_next  input  grid_t  combinational evolution of grid from the datapath.
REQ-012 SHALL have port grid  output  grid_t  registered current generation; drives datapath input and display.
REQ-013 SHALL have port gen_count  output  GEN_W  generations committed since last seed.
REQ-014 SHALL have port gen_valid  output  1  one-cycle pulse in the cycle after each commit or seed load.
REQ-015 SHALL have port stable  output  1  last commit produced grid_next == grid.
REQ-016 SHALL have port extinct  output  1  grid all-zero.
REQ-017 SHALL have port halted  output  1  state == HALTED.

Function
REQ-018 SHALL implement states EMPTY, PAUSED, RUNNING, HALTED.
REQ-019 SHALL assert seed_ready in every state; a seed load has priority over step, run and tick commits in the same cycle.
REQ-020 On seed load, SHALL set grid <= seed, gen_count <= 0, tick counter <= 0, stable <= 0, extinct <= (seed == 0), pulse gen_valid next cycle.
REQ-021 After seed load, SHALL enter HALTED if seed == 0 and halt_en = 1, else RUNNING if run = 1, else PAUSED.
REQ-022 EMPTY SHALL ignore run and step; only a seed load exits EMPTY.
REQ-023 PAUSED -> RUNNING when run = 1; RUNNING -> PAUSED when run = 0, with tick counter cleared.
REQ-024 In RUNNING, tick counter SHALL count 0..TICK_DIV-1; commit in the cycle it equals TICK_DIV-1, then wrap to 0.
REQ-025 In PAUSED, a step pulse SHALL commit in that cycle; step is ignored in RUNNING, HALTED and EMPTY.
REQ-026 A commit SHALL set grid <= grid_next, gen_count <= gen_count+1 saturating at 2^GEN_W-1, stable <= (grid_next == grid), extinct <= (grid_next == 0).
REQ-027 If halt_en = 1 and the commit sets stable or extinct, SHALL enter HALTED in the same edge.
REQ-028 HALTED SHALL hold grid and gen_count; exits only on seed load; run and step ignored.
REQ-029 Commit latency: grid and gen_count update on the clock edge ending the commit cycle; gen_valid high the following cycle only.
REQ-030 halt_en deasserted SHALL never cause HALTED via commit; a stable grid keeps committing with gen_count incrementing.

Reset
REQ-031 rst high SHALL asynchronously force state EMPTY, grid 0, gen_count 0, tick counter 0, gen_valid 0, stable 0, extinct 1, halted 0.
REQ-032 Reset mid-generation SHALL abort the pending commit; first commit after reset requires a new seed load.
REQ-033 seed_ready SHALL be 0 while rst is high and 1 from the first edge after release.

Structure
REQ-034 grid_t and grid dimensions SHALL come from the shared types package; state enum life_state_t SHALL be added there.
REQ-035 SHALL contain one sub-module, tick_divider (parameter TICK_DIV; inputs clk, rst, clr, en; output tick).
REQ-036 SHALL not instantiate the evolution datapath; grid / grid_next connect to it at the top level.
REQ-037 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-038 TICK_DIV=4, 5x5 blinker seed, run=1 -> commits every 4 cycles, grid alternates horizontal/vertical, gen_count 1,2,3, stable stays 0.
REQ-039 run=0, 2x2 block seed, halt_en=1, step pulse -> gen_count=1, stable=1, halted=1; further step pulses leave gen_count=1.
REQ-040 Single live cell seed, halt_en=1, step -> extinct=1, halted=1, grid 0; all-zero seed with halt_en=1 -> halted next cycle, gen_count 0.
REQ-041 GEN_W=3, blinker, halt_en=0, run=1 for 10 commits -> gen_count saturates at 7, grid keeps oscillating.
REQ-042 Seed load in the same cycle as a tick commit -> grid equals new seed, gen_count 0; rst asserted mid-count -> outputs match REQ-031 immediately, no commit.
